mcpu_prog_loader: RTL and testbench
===================================

Name: mcpu_prog_loader

Overview:
Byte-stream program loader that sits directly upstream of MCPU. It receives a framed program image over a valid/ready byte interface and assembles 16-bit instruction words. It writes those words into the MCPU RAM from address 0 upward. It holds the CPU in reset until a frame has loaded and passed its checksum, replacing backdoor preloading of RAM in the bench.

Parameters:
WORD_SIZE, 16, instruction word width (opcode + three operand nibbles); loader handles exactly 2 bytes per word
ADDR_SIZE, 8, RAM address width
RAM_SIZE, 256, number of RAM words (2**ADDR_SIZE)
HEADER, 8'hA5, frame start byte

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle
ram_we  output  1  one-cycle RAM write strobe
ram_addr  output  ADDR_SIZE  RAM write address
ram_wdata  output  WORD_SIZE  RAM write data
cpu_reset  output  1  active-high reset to MCPU
done  output  1  image loaded and checksum good
err  output  1  checksum mismatch on last frame
word_count  output  ADDR_SIZE+1  words written in current frame

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_reset=1, done=0, err=0, word_count=0, checksum=0.
- A byte is accepted on a rising clk edge when in_valid && in_ready. in_ready is registered. It goes to 1 on the first edge after reset deasserts and is 0 only in DONE.
- Frame format: HEADER, LEN, then LEN words (each high byte, then low byte), then CSUM.
  - LEN=0 means 256 words.
  - CSUM = XOR of all word bytes only. HEADER and LEN are excluded.
- States:
  - IDLE: accepted byte == HEADER -> LEN; other bytes are discarded. On entry, clear checksum, word_count and ram_addr.
  - LEN: latch remaining = (byte==0 ? 256 : byte) -> HI.
  - HI: latch byte as word[15:8], checksum ^= byte -> LO.
  - LO: checksum ^= byte.
    - The edge accepting LO drives ram_wdata={hi,byte} and ram_addr=word_count[ADDR_SIZE-1:0], and sets ram_we=1 for exactly the next cycle.
    - The same edge increments word_count.
    - Next state: if remaining words == 0 after this word -> CSUM, else -> HI.
  - CSUM: accepted byte == checksum -> DONE; otherwise -> ERR.
  - DONE: done=1, cpu_reset=0, in_ready=0. Held until reset; further bytes are never accepted.
  - ERR: err=1, cpu_reset=1, in_ready=1. A HEADER byte clears err and restarts the frame (-> LEN); other bytes are discarded.
- Write latency: ram_we is high in the cycle after the LO byte is accepted. RAM captures on that cycle's clock edge.
- Back-to-back words: if bytes arrive every cycle, the ram_we for word k coincides with acceptance of word k+1's HI byte. There is no stall.
- ram_addr wraps naturally. A 256-word frame writes addresses 0..255; word_count reaches 256.
- in_valid low in any state: hold state, no counter or checksum change.
- Reset mid-frame: everything returns to reset values and cpu_reset stays 1. Partially written RAM is not cleared; a new frame overwrites it.
- cpu_reset falls on the same edge that done rises. cpu_reset never pulses low in any other state.

Test Plan:
- Normal load: stream A5 02 12 34 AB CD 40 with in_valid=1 every cycle -> RAM writes mem[0]=16'h1234, then mem[1]=16'hABCD, each ram_we 1 cycle wide. After that: done=1, cpu_reset=0, word_count=2, in_ready=0.
- Bad checksum: A5 01 00 FF 00 -> mem[0]=16'h00FF written, err=1, done=0, cpu_reset=1. Then A5 01 00 FF FF -> err=0, done=1.
- Gaps and junk: 00 7E before A5, plus in_valid toggled low between every byte of A5 01 C3 3C FF -> junk is ignored. The result is identical to a gap-free stream: mem[0]=16'hC33C, done=1.
- Full image: LEN=00, 256 words with word i = {i[7:0], ~i[7:0]}, CSUM=00 -> 256 writes at addresses 0..255, word_count=256, done=1. There is no write to address 0 after address 255.
- Reset mid-operation: assert reset after the HI byte of word 1 -> all outputs return to reset values immediately (async). A following clean frame loads from address 0.

Source files
------------

// File: rtl/mcpu_prog_loader.sv
// Purpose: assembles a framed byte stream (HEADER, LEN, word bytes, CSUM) into 16-bit words and writes them into MCPU RAM from address 0 upward.
// Latency: ram_we is high in the cycle after a word's low byte is accepted; done/err are registered on the edge that accepts CSUM.
// Backpressure: in_ready is registered and stays high, except in DONE where it drops and holds until reset; cpu_reset is released only in DONE.
module mcpu_prog_loader #(
  parameter int          WORD_SIZE = 16,
  parameter int          ADDR_SIZE = 8,
  parameter int          RAM_SIZE  = 256,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_SIZE:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t             state;
  logic [7:0]         checksum;
  logic [7:0]         hi_byte;
  logic [ADDR_SIZE:0] remaining;
  logic               accept;

  assign accept = in_valid && in_ready;

  // Frame parser: one byte per accepted handshake, all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      checksum   <= '0;
      hi_byte    <= '0;
      remaining  <= '0;
    end else begin
      // Write strobe is a single-cycle pulse by default.
      ram_we <= 1'b0;
      // Ready rises on the first edge out of reset; only DONE holds it low.
      if (state != DONE) in_ready <= 1'b1;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == HEADER) begin
              checksum   <= '0;
              word_count <= '0;
              ram_addr   <= '0;
              state      <= LEN;
            end
          end
          LEN: begin
            // A zero length byte encodes a full-RAM image.
            remaining <= (in_data == 8'h00) ? (ADDR_SIZE+1)'(RAM_SIZE)
                                            : (ADDR_SIZE+1)'(in_data);
            state     <= HI;
          end
          HI: begin
            hi_byte  <= in_data;
            checksum <= checksum ^ in_data;
            state    <= LO;
          end
          LO: begin
            checksum   <= checksum ^ in_data;
            ram_wdata  <= {hi_byte, in_data};
            ram_addr   <= word_count[ADDR_SIZE-1:0];
            ram_we     <= 1'b1;
            word_count <= word_count + 1'b1;
            remaining  <= remaining - 1'b1;
            state      <= (remaining == (ADDR_SIZE+1)'(1)) ? CSUM : HI;
          end
          CSUM: begin
            if (in_data == checksum) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              in_ready  <= 1'b0;
              state     <= DONE;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
          ERR: begin
            // A fresh header retries the load from address 0.
            if (in_data == HEADER) begin
              err        <= 1'b0;
              checksum   <= '0;
              word_count <= '0;
              ram_addr   <= '0;
              state      <= LEN;
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Purpose: randomized and directed frames checked against a frame-level model through a write scoreboard.
// Latency: expected RAM writes are queued at stimulus time and matched in order on each ram_we pulse.
// Backpressure: the driver waits on in_ready with a bounded cycle budget.
module tb_mcpu_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [8:0]  word_count;

  int checks = 0;
  int failures = 0;
  int stalls = 0;

  logic [23:0] exp_q[$];
  logic [15:0] fw[$];
  logic [7:0]  jq[$];

  mcpu_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued write.
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset && ram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("ram_write", {8'h00, ram_addr, ram_wdata}, {8'h00, e});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n = 0;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      stalls++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  // Model: a frame of N words produces writes (i, word_i) for i=0..N-1;
  // the load succeeds iff the CSUM byte equals the XOR of all word bytes.
  task automatic run_frame(input int gap_pct, input logic [7:0] bad_xor);
    logic [7:0] cs = 8'h00;
    int n = fw.size();
    bit good = (bad_xor == 8'h00);
    foreach (fw[i]) begin
      cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
      exp_q.push_back({i[7:0], fw[i]});
    end
    cs = cs ^ bad_xor;
    stalls = 0;
    foreach (jq[i]) send_byte(jq[i], gap_pct);
    jq.delete();
    send_byte(8'hA5, gap_pct);
    send_byte(8'(n), gap_pct);
    foreach (fw[i]) begin
      send_byte(fw[i][15:8], gap_pct);
      send_byte(fw[i][7:0], gap_pct);
    end
    send_byte(cs, gap_pct);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done", done, good);
    chk("err", err, !good);
    chk("cpu_reset", cpu_reset, !good);
    chk("word_count", word_count, n);
    chk("in_ready", in_ready, !good);
    chk("writes_drained", exp_q.size(), 0);
    if (gap_pct == 0) chk("no_stall", stalls, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_word_count", word_count, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", in_ready, 1);
  endtask

  initial begin
    logic [7:0] b;
    int len;

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Normal two-word load, back-to-back bytes.
    fw = '{16'h1234, 16'hABCD};
    run_frame(0, 8'h00);

    // Bytes offered in DONE must never be taken.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("done_hold", done, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_cpu_reset", cpu_reset, 0);

    // Bad checksum, then a retry from ERR.
    do_reset();
    fw = '{16'h00FF};
    run_frame(0, 8'hFF);
    run_frame(0, 8'h00);

    // Junk before the header and idle gaps between bytes.
    do_reset();
    fw = '{16'hC33C};
    jq = '{8'h00, 8'h7E};
    run_frame(100, 8'h00);

    // Full 256-word image; LEN byte encodes as 0.
    do_reset();
    fw.delete();
    for (int i = 0; i < 256; i++) fw.push_back({i[7:0], ~i[7:0]});
    run_frame(0, 8'h00);

    // Reset after the high byte of word 1.
    do_reset();
    exp_q.push_back({8'h00, 16'h1122});
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    chk("midframe_writes", exp_q.size(), 0);
    do_reset();
    fw = '{16'hBEEF, 16'h0102};
    run_frame(0, 8'h00);

    // Randomized frames, some with corrupted checksums.
    for (int f = 0; f < 10; f++) begin
      do_reset();
      fw.delete();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) fw.push_back(16'($urandom));
      for (int j = 0; j < $urandom_range(0, 3); j++) begin
        b = 8'($urandom_range(255));
        if (b == 8'hA5) b = 8'h00;
        jq.push_back(b);
      end
      if ($urandom_range(3) == 0) begin
        run_frame((f % 2) * 30, 8'($urandom_range(1, 255)));
        fw.delete();
        for (int i = 0; i < 3; i++) fw.push_back(16'($urandom));
      end
      run_frame((f % 2) * 30, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
